// File: rtl/acc_if_pkg.sv
// Shared types and constants for the accumulator-core method-interface initiator.
package acc_if_pkg;

    localparam int DW = 8;

    // Bit positions inside the packed {err, ovf} result flag vector.
    localparam int FLAG_OVF = 0;
    localparam int FLAG_ERR = 1;
    localparam int FLAG_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WAIT,
        ST_RESP
    } acc_mst_state_e;

endpackage

// File: rtl/acc_shadow_sum.sv
// Shadow copy of the core's running sum; flags signed overflow, sticky until cleared.
module acc_shadow_sum
    import acc_if_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] x,
    output logic          ovf
);

    logic [DW-1:0] sum;
    logic [DW-1:0] sum_next;

    assign sum_next = sum + x;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            sum <= sum_next;
            // Same-sign operands producing a sign flip is two's-complement overflow.
            if ((sum[DW-1] == x[DW-1]) && (sum_next[DW-1] != sum[DW-1]))
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/acc_stream_master.sv
// Frame initiator: programs len, streams samples into din, drains dout, reports upstream.
module acc_stream_master
    import acc_if_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] cmd_len,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] smp_data,
    input  logic          smp_valid,
    output logic          smp_ready,
    output logic [DW-1:0] res_data,
    output logic          res_ovf,
    output logic          res_err,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] len_value,
    output logic          len_en,
    input  logic          len_rdy,
    output logic [DW-1:0] din_value,
    output logic          din_en,
    input  logic          din_rdy,
    input  logic [DW-1:0] dout_value,
    output logic          dout_en,
    input  logic          dout_rdy,
    output logic          busy
);

    acc_mst_state_e state, state_next;

    logic [DW-1:0]     rem;
    logic [TW-1:0]     tcnt;
    logic              err;
    logic              ovf_sticky;
    logic              cmd_acc;
    logic              wait_tmo;
    logic [FLAG_W-1:0] flags;

    assign cmd_acc   = cmd_valid & cmd_ready;
    assign wait_tmo  = (state == ST_WAIT) && !dout_rdy && (tcnt == TW'(TIMEOUT - 1));
    assign din_value = smp_data;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        smp_ready  = 1'b0;
        len_en     = 1'b0;
        din_en     = 1'b0;
        dout_en    = 1'b0;
        res_valid  = 1'b0;
        // Reset masks all handshakes so the core sees no traffic in the reset cycle.
        if (!RST) begin
            unique case (state)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) state_next = (cmd_len == '0) ? ST_RESP : ST_LEN;
                end
                ST_LEN: begin
                    len_en = len_rdy;
                    if (len_rdy) state_next = ST_DATA;
                end
                ST_DATA: begin
                    din_en    = din_rdy & smp_valid;
                    smp_ready = din_rdy & smp_valid;
                    if (din_en && rem == DW'(1)) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    dout_en = dout_rdy;
                    if (dout_rdy || wait_tmo) state_next = ST_RESP;
                end
                ST_RESP: begin
                    res_valid = 1'b1;
                    if (res_ready) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rem       <= '0;
            len_value <= '0;
            tcnt      <= '0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (cmd_acc) begin
                rem       <= cmd_len;
                len_value <= cmd_len;
                tcnt      <= '0;
                res_data  <= '0;
                err       <= (cmd_len == '0);
            end
            if (din_en) rem <= rem - DW'(1);
            if (dout_en) begin
                res_data <= dout_value;
            end else if (state == ST_WAIT) begin
                tcnt <= tcnt + TW'(1);
                if (wait_tmo) err <= 1'b1;
            end
        end
    end

    acc_shadow_sum u_shadow (
        .CLK (CLK),
        .RST (RST),
        .clr (cmd_acc),
        .en  (din_en),
        .x   (smp_data),
        .ovf (ovf_sticky)
    );

    assign flags[FLAG_ERR] = err;
    assign flags[FLAG_OVF] = ovf_sticky;
    assign res_err         = flags[FLAG_ERR];
    assign res_ovf         = flags[FLAG_OVF];

endmodule

// File: tb/tb_acc_stream_master.sv
// Directed bench for acc_stream_master with a negedge bus monitor and hand-computed results.
module tb_acc_stream_master;

    localparam int TMO = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] cmd_len = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] smp_data = '0;
    logic       smp_valid = 1'b0;
    logic       smp_ready;
    logic [7:0] res_data;
    logic       res_ovf, res_err, res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] len_value;
    logic       len_en;
    logic       len_rdy = 1'b1;
    logic [7:0] din_value;
    logic       din_en;
    logic       din_rdy = 1'b1;
    logic [7:0] dout_value = '0;
    logic       dout_en;
    logic       dout_rdy = 1'b1;
    logic       busy;

    acc_stream_master #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .res_data(res_data), .res_ovf(res_ovf), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready),
        .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
        .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
        .dout_value(dout_value), .dout_en(dout_en), .dout_rdy(dout_rdy),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bus monitor sampled on the falling edge, well away from the active edge.
    int         cyc = 0, n_len = 0, n_din = 0, n_dout = 0, n_coinc = 0, n_viol = 0;
    int         last_din_cyc = 0, rv_cyc = 0;
    logic       rv_q = 1'b0;
    logic [7:0] len_seen = '0;
    logic [7:0] din_log [$];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (len_en) begin
            n_len    <= n_len + 1;
            len_seen <= len_value;
        end
        if (din_en) begin
            n_din        <= n_din + 1;
            last_din_cyc <= cyc;
            din_log.push_back(din_value);
        end
        if (dout_en) n_dout <= n_dout + 1;
        if ((int'(len_en) + int'(din_en) + int'(dout_en)) > 1) n_coinc <= n_coinc + 1;
        if ((din_en && !(din_rdy && smp_valid)) || (len_en && !len_rdy) || (dout_en && !dout_rdy))
            n_viol <= n_viol + 1;
        if (res_valid && !rv_q) rv_cyc <= cyc;
        rv_q <= res_valid;
    end

    logic [7:0] vec [8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len);
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) step();
        check("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic push_samples(input int n, input bit rnd);
        int idx = 0;
        for (int c = 0; c < 400 && idx < n; c++) begin
            smp_data  = vec[idx];
            smp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            din_rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (smp_ready) idx++;
            @(posedge CLK);
            #1;
        end
        smp_valid = 1'b0;
        din_rdy   = 1'b1;
        check("push_done", 32'(idx), 32'(n));
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 100 && !res_valid; i++) step();
        check("res_valid", res_valid, 1);
    endtask

    task automatic run_frame(input int n, input logic [7:0] dval, input bit drdy, input bit rnd,
                             input logic [7:0] e_data, input bit e_ovf, input bit e_err);
        int b_len  = n_len;
        int b_din  = n_din;
        int b_dout = n_dout;
        int b_log  = din_log.size();
        dout_value = dval;
        dout_rdy   = drdy;
        send_cmd(8'(n));
        if (n == 0) check("zero_len_resp_next_cycle", res_valid, 1);
        else push_samples(n, rnd);
        wait_resp();
        check("res_data", res_data, e_data);
        check("res_ovf", res_ovf, e_ovf);
        check("res_err", res_err, e_err);
        check("len_en_count", 32'(n_len - b_len), (n == 0) ? 0 : 1);
        if (n != 0) check("len_value", len_seen, 32'(n));
        check("din_en_count", 32'(n_din - b_din), 32'(n));
        for (int i = 0; i < n; i++) check("din_value", din_log[b_log + i], vec[i]);
        check("dout_en_count", 32'(n_dout - b_dout), (drdy && n != 0) ? 1 : 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        dout_rdy  = 1'b1;
        check("idle_after_resp", {busy, cmd_ready, res_valid}, 3'b010);
    endtask

    initial begin
        int chg;
        logic [7:0] held;

        #1;
        check("reset_cmd_ready", cmd_ready, 0);
        step();
        step();
        RST = 1'b0;
        #1;
        check("post_reset_idle", {busy, cmd_ready, res_valid, res_ovf, res_err}, 5'b01000);
        check("post_reset_res_data", res_data, 0);

        // 1: basic three-sample frame.
        vec = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(3, 8'd6, 1'b1, 1'b0, 8'd6, 1'b0, 1'b0);

        // 2: signed overflow cases.
        vec = '{8'd100, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(2, 8'd150, 1'b1, 1'b0, 8'd150, 1'b1, 1'b0);
        vec = '{8'h80, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(2, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0);
        vec = '{8'h7F, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(2, 8'h7E, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0);

        // 3: zero-length command aborts without core traffic.
        run_frame(0, 8'hAA, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

        // 4: five samples with randomly toggling valid/ready.
        vec = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
        run_frame(5, 8'd150, 1'b1, 1'b1, 8'd150, 1'b1, 1'b0);
        check("enable_exclusive", 32'(n_coinc), 0);
        check("enable_without_rdy", 32'(n_viol), 0);

        // 5: timeout in WAIT, then a normal single-sample frame.
        vec = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(2, 8'h33, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        check("timeout_wait_cycles", 32'(rv_cyc - last_din_cyc), 32'(TMO + 1));
        vec = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(1, 8'd7, 1'b1, 1'b0, 8'd7, 1'b0, 1'b0);

        // 6: reset after two of five samples.
        vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
        send_cmd(8'd5);
        push_samples(2, 1'b0);
        smp_data  = vec[2];
        smp_valid = 1'b1;
        RST       = 1'b1;
        #1;
        check("reset_cycle_outputs", {len_en, din_en, dout_en, smp_ready, cmd_ready}, 5'b00000);
        step();
        RST       = 1'b0;
        smp_valid = 1'b0;
        #1;
        check("after_reset_state", {cmd_ready, res_valid, busy}, 3'b100);

        // Result held stable while res_ready stays low.
        vec = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        dout_value = 8'h5A;
        send_cmd(8'd1);
        push_samples(1, 1'b0);
        wait_resp();
        held = res_data;
        chg  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (res_data !== held || res_valid !== 1'b1 || res_err !== 1'b0) chg++;
        end
        check("resp_hold_changes", 32'(chg), 0);
        check("resp_hold_data", res_data, 8'h5A);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("final_idle", {busy, res_valid}, 2'b00);
        check("final_exclusive", 32'(n_coinc + n_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_stream_master.md
Name: acc_stream_master

Overview:
- Host-side initiator for the accumulator core's method interface (len / din / dout).
- Accepts a frame command (sample count) and a byte sample stream from upstream.
- Programs the length, pushes exactly that many samples, then drains the single result.
- Returns the result upstream with overflow and error flags; the core never sees len_en and din_en in the same cycle.

Parameters:
DW, 8, sample/result width (fixed 8 to match core)
TIMEOUT, 1024, max consecutive WAIT cycles with dout_rdy low before abort
TW, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
cmd_len  in  8  frame sample count
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
smp_data  in  8  sample byte (signed)
smp_valid  in  1  sample valid
smp_ready  out  1  sample consumed when valid&ready
res_data  out  8  result captured from dout_value
res_ovf  out  1  signed 8-bit overflow seen in pushed samples
res_err  out  1  frame aborted (len 0 or timeout)
res_valid  out  1  result valid
res_ready  in  1  result accepted
len_value  out  8  to core len method
len_en  out  1  len method enable
len_rdy  in  1  len method ready
din_value  out  8  to core din method
din_en  out  1  din method enable
din_rdy  in  1  din method ready
dout_value  in  8  core result
dout_en  out  1  dout method enable
dout_rdy  in  1  dout method ready
busy  out  1  state != IDLE

Behaviour:
- Clock CLK; reset RST synchronous, active-high. In reset: state IDLE, res_valid/res_ovf/res_err=0, res_data=0, counters 0.
- Reset effect: in any cycle with RST=1, all *_en outputs and smp_ready are 0 and cmd_ready is 0.
- States: IDLE, LEN, DATA, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch len into rem and len_value; clear shadow sum S, ovf, err, timeout counter.
  - cmd_len==0 -> RESP with res_data=0, res_err=1, no core traffic. Otherwise -> LEN.
- LEN: len_en = len_rdy (combinational); on len_en -> DATA.
- DATA:
  - din_en = smp_ready = din_rdy & smp_valid; din_value = smp_data (pass-through, zero latency).
  - Each handshake: rem-=1; S_next = S + smp_data mod 256; ovf |= (S[7]==x[7]) & (S_next[7]!=S[7]).
  - Handshake with rem==1 -> WAIT.
- WAIT:
  - dout_en = dout_rdy; on dout_en, capture dout_value into res_data -> RESP.
  - Each cycle with dout_rdy=0: tcnt+=1. When tcnt reaches TIMEOUT -> RESP with res_err=1, res_data=0, and no dout_en issued.
- RESP: res_valid=1; hold res_data/res_ovf/res_err stable until res_ready -> IDLE. cmd_ready is 0 in RESP, giving a one-cycle bubble between frames.
- Enable exclusivity: only one of len_en/din_en/dout_en can be high in any cycle (state-decoded).
- Stall tolerance: no enable is asserted without its rdy. Stalls on smp_valid or din_rdy have no time limit.
- Reset mid-frame: the next cycle is IDLE; unconsumed samples stay upstream and there is no partial result.
- busy: high in LEN, DATA, WAIT, RESP.

Decomposition:
- Package acc_if_pkg:
  - state enum acc_mst_state_e
  - DW localparam
  - flag bit positions for {err, ovf}
- Sub-module acc_shadow_sum: accumulates S, computes sticky ovf; inputs clr, en, x; outputs ovf.

Test Plan:
1. cmd_len=3, samples 1,2,3, core returns dout_value=6 -> one len_en with len_value=3, three din_en with 1,2,3, one dout_en, then res_data=6 ovf=0 err=0.
2. cmd_len=2, samples 100,50 (sum 150) -> res_ovf=1, res_err=0. Samples -128,-1 -> res_ovf=1. Samples 127,-1 -> res_ovf=0.
3. cmd_len=0 -> len_en/din_en/dout_en never asserted; res_valid=1 with res_data=0 err=1 in the cycle after acceptance.
4. cmd_len=5 with din_rdy and smp_valid randomly toggled -> exactly 5 din_en pulses, each only with both high, and never coincident with len_en.
5. TIMEOUT=16, dout_rdy held 0 -> res_err=1 after 16 WAIT cycles, dout_en never high. A following command of len=1 completes normally.
6. RST=1 after 2 of 5 samples, held one cycle -> en outputs 0 in the reset cycle, then cmd_ready=1, res_valid=0, busy=0. Holding res_ready=0 in RESP for 10 cycles keeps the result stable.
